// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single FIFO write port among N_REQ
//   requesters. A requester owns the port for at most MAX_BURST beats, then
//   the port goes through one IDLE cycle before the next owner is picked.
//   A grant never moves while the owner is stalled by a full FIFO.
//
// Ports
//   clk_wr    write-domain clock (rising edge)
//   rst       synchronous active-high reset
//   req       per-requester write request, held with data until granted
//   req_data  packed request words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      FIFO full flag
//   gnt       one-hot beat acknowledge (same cycle as the FIFO write)
//   en_wr     FIFO write enable
//   Din       FIFO write data (0 when en_wr is low)
//   busy      high while a burst is in progress
//   owner     current / most recent burst owner
//   wr_count  accepted beats since reset, free-running 16-bit
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_wr,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                          full,
    output logic [N_REQ-1:0]              gnt,
    output logic                          en_wr,
    output logic [DATA_WIDTH-1:0]         Din,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      owner,
    output logic [15:0]                   wr_count
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   rr_ptr, rr_ptr_nxt, owner_nxt, sel;
    logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
    logic [15:0]     wr_count_nxt;
    logic            sel_vld, own_req, accept, last_beat;

    // Index base+k reduced modulo N_REQ (k < N_REQ, so one subtraction suffices).
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return OW'(s);
    endfunction

    // Rotating priority search starting at rr_ptr. Scanning from the farthest
    // offset down lets the closest requester overwrite the others.
    always_comb begin
        sel     = rr_ptr;
        sel_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                sel     = wrap_add(rr_ptr, k);
                sel_vld = 1'b1;
            end
        end
    end

    assign own_req   = req[owner];
    assign accept    = (state == BURST) && own_req && !full && !rst;
    assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));
    assign busy      = (state == BURST);
    assign en_wr     = accept;
    assign Din       = accept ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH]
                              : '0;

    always_comb begin
        gnt = '0;
        if (accept) gnt[owner] = 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        wr_count_nxt  = wr_count;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt     = BURST;
                    owner_nxt     = sel;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    wr_count_nxt  = wr_count + 16'd1;
                end
                // Leave on the final written beat, or as soon as the owner
                // drops its request (no beat that cycle). A full stall with
                // the request held keeps the grant.
                if ((accept && last_beat) || !own_req) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = wrap_add(owner, 1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            wr_count  <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            wr_count  <= wr_count_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2
// units later, well before the next edge.
module tb_fifo_wr_arbiter;

    logic        clk_wr;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  gnt;
    logic        en_wr;
    logic [7:0]  Din;
    logic        busy;
    logic [1:0]  owner;
    logic [15:0] wr_count;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk_wr   (clk_wr),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .en_wr    (en_wr),
        .Din      (Din),
        .busy     (busy),
        .owner    (owner),
        .wr_count (wr_count)
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        full;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        en;
        logic [7:0]  din;
        logic        cs;     // check busy/owner/wr_count
        logic        busy;
        logic [1:0]  own;
        logic [15:0] wrc;
        logic        cb;     // check burst counter
        logic [2:0]  bcnt;
        logic        cr;     // check round-robin pointer
        logic [1:0]  rrp;
    } vec_t;

    vec_t vq[$];

    function automatic void addv(
        input logic r, input logic [3:0] rq, input logic f, input logic [31:0] d,
        input logic [3:0] g, input logic e, input logic [7:0] dn,
        input logic cs, input logic b, input logic [1:0] o, input logic [15:0] w,
        input logic cb, input logic [2:0] bc, input logic cr, input logic [1:0] rp);
        vec_t t;
        t = '{r, rq, f, d, g, e, dn, cs, b, o, w, cb, bc, cr, rp};
        vq.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_wr);
        #1;
    endtask

    localparam logic [31:0] DRR = 32'hD3C2_B1A0;

    initial begin
        logic [7:0] rr_byte [4];
        rr_byte = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        // ---------------- vector table ----------------
        // reset with all requests high (state not checked before first edge)
        addv(1, 4'hF, 0, DRR, 4'h0, 0, 8'h00, 0, 0, 0, 16'd0,  0, 0, 0, 0);
        addv(1, 4'hF, 0, DRR, 4'h0, 0, 8'h00, 1, 0, 0, 16'd0,  1, 0, 1, 0);
        addv(0, 4'hF, 0, DRR, 4'h0, 0, 8'h00, 1, 0, 0, 16'd0,  0, 0, 0, 0);
        // round robin: owners 0..3, 4 beats each, bubble after each burst
        for (int o = 0; o < 4; o++) begin
            for (int b = 0; b < 4; b++)
                addv(0, 4'hF, 0, DRR, 4'b0001 << o, 1, rr_byte[o], 1, 1, 2'(o),
                     16'(o*4 + b), 1, 3'(b), 0, 0);
            addv(0, (o == 3) ? 4'h0 : 4'hF, 0, DRR, 4'h0, 0, 8'h00, 1, 0, 2'(o),
                 16'(o*4 + 4), 0, 0, 1, 2'((o + 1) % 4));
        end
        // single requester 2, data advances on each grant
        addv(0, 4'h4, 0, 32'h0020_0000, 4'h0, 0, 8'h00, 1, 0, 3, 16'd16, 0, 0, 1, 0);
        addv(0, 4'h4, 0, 32'h0020_0000, 4'h4, 1, 8'h20, 1, 1, 2, 16'd16, 1, 0, 0, 0);
        addv(0, 4'h4, 0, 32'h0021_0000, 4'h4, 1, 8'h21, 1, 1, 2, 16'd17, 0, 0, 0, 0);
        addv(0, 4'h4, 0, 32'h0022_0000, 4'h4, 1, 8'h22, 1, 1, 2, 16'd18, 0, 0, 0, 0);
        addv(0, 4'h4, 0, 32'h0023_0000, 4'h4, 1, 8'h23, 1, 1, 2, 16'd19, 1, 3, 0, 0);
        addv(0, 4'h4, 0, 32'h0024_0000, 4'h0, 0, 8'h00, 1, 0, 2, 16'd20, 0, 0, 1, 3);
        addv(0, 4'h4, 0, 32'h0024_0000, 4'h4, 1, 8'h24, 1, 1, 2, 16'd20, 1, 0, 0, 0);
        addv(0, 4'h4, 0, 32'h0025_0000, 4'h4, 1, 8'h25, 1, 1, 2, 16'd21, 0, 0, 0, 0);
        addv(0, 4'h0, 0, 32'h0000_0000, 4'h0, 0, 8'h00, 1, 1, 2, 16'd22, 1, 2, 0, 0);
        addv(0, 4'h0, 0, 32'h0000_0000, 4'h0, 0, 8'h00, 1, 0, 2, 16'd22, 0, 0, 1, 3);
        // full stall on owner 1 after two beats
        addv(0, 4'h2, 0, 32'h0000_3000, 4'h0, 0, 8'h00, 1, 0, 2, 16'd22, 0, 0, 0, 0);
        addv(0, 4'h2, 0, 32'h0000_3000, 4'h2, 1, 8'h30, 1, 1, 1, 16'd22, 1, 0, 0, 0);
        addv(0, 4'h2, 0, 32'h0000_3100, 4'h2, 1, 8'h31, 1, 1, 1, 16'd23, 1, 1, 0, 0);
        for (int s = 0; s < 3; s++)
            addv(0, 4'h2, 1, 32'h0000_3200, 4'h0, 0, 8'h00, 1, 1, 1, 16'd24, 1, 2, 0, 0);
        addv(0, 4'h2, 0, 32'h0000_3200, 4'h2, 1, 8'h32, 1, 1, 1, 16'd24, 1, 2, 0, 0);
        addv(0, 4'h2, 0, 32'h0000_3300, 4'h2, 1, 8'h33, 1, 1, 1, 16'd25, 1, 3, 0, 0);
        addv(0, 4'h0, 0, 32'h0000_0000, 4'h0, 0, 8'h00, 1, 0, 1, 16'd26, 0, 0, 1, 2);
        // early release by owner 0 while requester 3 waits
        addv(0, 4'h1, 0, 32'h7000_0040, 4'h0, 0, 8'h00, 1, 0, 1, 16'd26, 0, 0, 0, 0);
        addv(0, 4'h9, 0, 32'h7000_0040, 4'h1, 1, 8'h40, 1, 1, 0, 16'd26, 0, 0, 0, 0);
        addv(0, 4'h8, 0, 32'h7000_0040, 4'h0, 0, 8'h00, 1, 1, 0, 16'd27, 0, 0, 0, 0);
        addv(0, 4'h8, 0, 32'h7000_0040, 4'h0, 0, 8'h00, 1, 0, 0, 16'd27, 0, 0, 1, 1);
        addv(0, 4'h8, 0, 32'h7000_0040, 4'h8, 1, 8'h70, 1, 1, 3, 16'd27, 0, 0, 0, 0);
        addv(0, 4'h0, 0, 32'h0000_0000, 4'h0, 0, 8'h00, 1, 1, 3, 16'd28, 0, 0, 0, 0);
        addv(0, 4'h0, 0, 32'h0000_0000, 4'h0, 0, 8'h00, 1, 0, 3, 16'd28, 0, 0, 1, 0);

        // ---------------- apply table ----------------
        foreach (vq[i]) begin
            rst      = vq[i].rst;
            req      = vq[i].req;
            full     = vq[i].full;
            req_data = vq[i].data;
            #2;
            chk("gnt",   i, 32'(gnt),   32'(vq[i].gnt));
            chk("en_wr", i, 32'(en_wr), 32'(vq[i].en));
            chk("Din",   i, 32'(Din),   32'(vq[i].din));
            if (vq[i].cs) begin
                chk("busy",     i, 32'(busy),     32'(vq[i].busy));
                chk("owner",    i, 32'(owner),    32'(vq[i].own));
                chk("wr_count", i, 32'(wr_count), 32'(vq[i].wrc));
            end
            if (vq[i].cb) chk("burst_cnt", i, 32'(dut.burst_cnt), 32'(vq[i].bcnt));
            if (vq[i].cr) chk("rr_ptr",    i, 32'(dut.rr_ptr),    32'(vq[i].rrp));
            next_cycle();
        end

        // ---------------- wr_count wrap ----------------
        // From reset with all requests high, cycle k carries a beat unless
        // k%5==0; cycles 0..81918 hold 65535 beats, cycle 81919 is the final
        // beat of owner 3's burst.
        rst = 1; req = 4'hF; full = 0; req_data = DRR;
        next_cycle();
        rst = 0;
        repeat (81919) next_cycle();
        #2;
        chk("wrap_wrc_pre", 0, 32'(wr_count), 32'h0000_FFFF);
        chk("wrap_en",      0, 32'(en_wr),    32'd1);
        chk("wrap_gnt",     0, 32'(gnt),      32'h8);
        chk("wrap_din",     0, 32'(Din),      32'hD3);
        next_cycle();
        req = 4'hE;
        #2;
        chk("wrap_wrc_post", 1, 32'(wr_count), 32'd0);
        chk("wrap_idle",     1, 32'(busy),     32'd0);

        // ---------------- reset mid-burst ----------------
        next_cycle();
        #2;
        chk("mid_gnt",   0, 32'(gnt),   32'h2);
        chk("mid_owner", 0, 32'(owner), 32'd1);
        next_cycle();
        rst = 1;
        #2;
        chk("rstc_gnt",   1, 32'(gnt),   32'd0);
        chk("rstc_en_wr", 1, 32'(en_wr), 32'd0);
        chk("rstc_din",   1, 32'(Din),   32'd0);
        next_cycle();
        rst = 0; req = 4'h0;
        #2;
        chk("post_busy",  2, 32'(busy),          32'd0);
        chk("post_owner", 2, 32'(owner),         32'd0);
        chk("post_wrc",   2, 32'(wr_count),      32'd0);
        chk("post_bcnt",  2, 32'(dut.burst_cnt), 32'd0);
        chk("post_rrp",   2, 32'(dut.rr_ptr),    32'd0);
        chk("post_en_wr", 2, 32'(en_wr),         32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
